// File: rtl/halt_dump_unit.sv
// End-of-program monitor: detects the trap word or a RUN-cycle timeout, freezes the pipeline,
// drains it, then streams a window of data memory out over a valid/ready channel.
module halt_dump_unit #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           WORD_BYTES     = 4,
    parameter logic [ADDR_WIDTH-1:0] DUMP_BASE      = ADDR_WIDTH'(8192),
    parameter int unsigned           DUMP_WORDS     = 10,
    parameter logic [DATA_WIDTH-1:0] TRAP_WORD      = DATA_WIDTH'(32'h4400_0300),
    parameter int unsigned           DRAIN_CYCLES   = 4,
    parameter int unsigned           TIMEOUT_CYCLES = 25000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic                  halt,
    output logic                  dmem_rd_en,
    output logic [ADDR_WIDTH-1:0] dmem_rd_addr,
    input  logic [DATA_WIDTH-1:0] dmem_rd_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           cycle_count
);

    localparam int unsigned IDX_W   = (DUMP_WORDS > 0) ? $clog2(DUMP_WORDS + 1) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [31:0]           TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DRAIN  = 3'd1,
        S_RDREQ  = 3'd2,
        S_RDWAIT = 3'd3,
        S_SEND   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state;
    logic [DRAIN_W-1:0]    r_drain;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_halt;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_dump_addr;
    logic [DATA_WIDTH-1:0] r_dump_data;
    logic                  r_done;
    logic                  r_timeout;
    logic [31:0]           r_cycle;

    logic w_trap;
    logic w_timeout_hit;
    logic w_last_word;

    assign w_trap        = instr_valid && (instruction == TRAP_WORD);
    assign w_timeout_hit = (r_cycle == TIMEOUT_LAST);
    assign w_last_word   = (r_idx == LAST_IDX);

    // Control FSM with all outputs registered; the read address advances by stride so it wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_drain     <= '0;
            r_idx       <= '0;
            r_halt      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_valid     <= 1'b0;
            r_dump_addr <= '0;
            r_dump_data <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle     <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!(&r_cycle)) begin
                        r_cycle <= r_cycle + 32'd1;
                    end
                    // Trap has priority, so a simultaneous timeout leaves the timeout flag clear.
                    if (w_trap) begin
                        r_state <= S_DRAIN;
                        r_halt  <= 1'b1;
                        r_drain <= DRAIN_LOAD;
                    end else if (w_timeout_hit) begin
                        r_state   <= S_DRAIN;
                        r_halt    <= 1'b1;
                        r_drain   <= DRAIN_LOAD;
                        r_timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain <= DRAIN_W'(1)) begin
                        if (DUMP_WORDS == 0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_RDREQ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= DUMP_BASE;
                            r_idx     <= '0;
                        end
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                S_RDREQ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    r_dump_data <= dmem_rd_data;
                    r_dump_addr <= r_rd_addr;
                    r_valid     <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (dump_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_word) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_rd_addr <= r_rd_addr + ADDR_STEP;
                            r_rd_en   <= 1'b1;
                            r_state   <= S_RDREQ;
                        end
                    end
                end
                S_DONE: begin
                    r_halt  <= 1'b1;
                    r_done  <= 1'b1;
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_RUN;
                    r_halt  <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign halt         = r_halt;
    assign dmem_rd_en   = r_rd_en;
    assign dmem_rd_addr = r_rd_addr;
    assign dump_valid   = r_valid;
    assign dump_addr    = r_dump_addr;
    assign dump_data    = r_dump_data;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign cycle_count  = r_cycle;

endmodule

// File: tb/tb_halt_dump_unit.sv
// Scoreboard bench: four halt_dump_unit instances with different parameters, each with a DMEM
// model (word k = k*3+1) and a monitor that pops expected words on every dump handshake.
module tb_halt_dump_unit;

    localparam int          NI   = 4;
    localparam logic [31:0] TRAP = 32'h4400_0300;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset       [NI];
    logic        instr_valid [NI];
    logic [31:0] instruction [NI];
    logic        halt        [NI];
    logic        rd_en       [NI];
    logic [31:0] rd_addr     [NI];
    logic [31:0] rd_data     [NI];
    logic        dump_valid  [NI];
    logic        dump_ready  [NI];
    logic [31:0] dump_addr   [NI];
    logic [31:0] dump_data   [NI];
    logic        done        [NI];
    logic        timeout     [NI];
    logic [31:0] cycle_count [NI];
    int          rd_cnt      [NI];

    exp_t exp_q [NI][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gen_u
        localparam int unsigned P_TO   = (g == 1) ? 50 : 25000;
        localparam int unsigned P_DW   = (g == 2) ? 0 : ((g == 3) ? 4 : 10);
        localparam logic [31:0] P_BASE = (g == 3) ? 32'hFFFF_FFF8 : 32'd8192;

        logic        stall_q = 1'b0;
        logic [31:0] sa = 32'd0;
        logic [31:0] sd = 32'd0;

        halt_dump_unit #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORD_BYTES(4), .DUMP_BASE(P_BASE),
            .DUMP_WORDS(P_DW), .TRAP_WORD(TRAP), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(P_TO)
        ) u_dut (
            .clock(clock), .reset(reset[g]), .instr_valid(instr_valid[g]),
            .instruction(instruction[g]), .halt(halt[g]), .dmem_rd_en(rd_en[g]),
            .dmem_rd_addr(rd_addr[g]), .dmem_rd_data(rd_data[g]), .dump_valid(dump_valid[g]),
            .dump_ready(dump_ready[g]), .dump_addr(dump_addr[g]), .dump_data(dump_data[g]),
            .done(done[g]), .timeout(timeout[g]), .cycle_count(cycle_count[g])
        );

        // DMEM side port: one-cycle read latency, preloaded with word k = k*3+1
        always @(posedge clock) begin
            if (rd_en[g]) begin
                rd_data[g] <= (((rd_addr[g] - P_BASE) >> 2) * 32'd3) + 32'd1;
                rd_cnt[g]  <= rd_cnt[g] + 1;
            end
        end

        // Monitor: hold-stable check while stalled, scoreboard pop on each handshake
        always @(negedge clock) begin
            if (stall_q) begin
                chk($sformatf("u%0d hold_valid", g), 64'(dump_valid[g]), 64'd1);
                chk($sformatf("u%0d hold_addr", g), 64'(dump_addr[g]), 64'(sa));
                chk($sformatf("u%0d hold_data", g), 64'(dump_data[g]), 64'(sd));
            end
            stall_q <= dump_valid[g] && !dump_ready[g] && !reset[g];
            sa      <= dump_addr[g];
            sd      <= dump_data[g];
            if (dump_valid[g] && dump_ready[g] && !reset[g]) begin
                if (exp_q[g].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL u%0d unexpected_word: got addr %0h data %0h, expected none",
                             g, dump_addr[g], dump_data[g]);
                end else begin
                    chk($sformatf("u%0d word_addr", g), 64'(dump_addr[g]), 64'(exp_q[g][0].addr));
                    chk($sformatf("u%0d word_data", g), 64'(dump_data[g]), 64'(exp_q[g][0].data));
                    void'(exp_q[g].pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_words(input int g, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q[g].push_back({base + 32'(4 * k), 32'(3 * k + 1)});
        end
    endtask

    task automatic trap(input int g);
        instr_valid[g] = 1'b1;
        instruction[g] = TRAP;
        tick(1);
        instr_valid[g] = 1'b0;
        instruction[g] = 32'd0;
    endtask

    task automatic wait_done(input int g, input int maxc, output int cyc);
        cyc = 0;
        while (!done[g] && cyc < maxc) begin
            tick(1);
            cyc++;
        end
        chk($sformatf("u%0d done_reached", g), 64'(done[g]), 64'd1);
    endtask

    task automatic take_word(input int g, input int stall);
        int c = 0;
        while (!dump_valid[g] && c < 100) begin
            tick(1);
            c++;
        end
        chk($sformatf("u%0d valid_seen", g), 64'(dump_valid[g]), 64'd1);
        tick(stall);
        dump_ready[g] = 1'b1;
        tick(1);
        dump_ready[g] = 1'b0;
    endtask

    task automatic reset_check(input int g);
        chk($sformatf("u%0d rst_halt", g), 64'(halt[g]), 64'd0);
        chk($sformatf("u%0d rst_rd_en", g), 64'(rd_en[g]), 64'd0);
        chk($sformatf("u%0d rst_rd_addr", g), 64'(rd_addr[g]), 64'd0);
        chk($sformatf("u%0d rst_valid", g), 64'(dump_valid[g]), 64'd0);
        chk($sformatf("u%0d rst_dump_addr", g), 64'(dump_addr[g]), 64'd0);
        chk($sformatf("u%0d rst_dump_data", g), 64'(dump_data[g]), 64'd0);
        chk($sformatf("u%0d rst_done", g), 64'(done[g]), 64'd0);
        chk($sformatf("u%0d rst_timeout", g), 64'(timeout[g]), 64'd0);
        chk($sformatf("u%0d rst_cycles", g), 64'(cycle_count[g]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        for (int g = 0; g < NI; g++) begin
            reset[g]       = 1'b1;
            instr_valid[g] = 1'b0;
            instruction[g] = 32'd0;
            dump_ready[g]  = 1'b1;
        end
        tick(3);
        for (int g = 0; g < NI; g++) reset_check(g);

        // Trap at cycle 100, ready tied high
        push_words(0, 32'd8192, 10);
        s = rd_cnt[0];
        reset[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            instr_valid[0] = i[0];
            instruction[0] = TRAP ^ (32'h1 << (i % 32));
            tick(1);
        end
        chk("trap pre_count", 64'(cycle_count[0]), 64'd100);
        chk("trap pre_halt", 64'(halt[0]), 64'd0);
        trap(0);
        chk("trap halt_rise", 64'(halt[0]), 64'd1);
        chk("trap count_frozen", 64'(cycle_count[0]), 64'd101);
        chk("trap drain_rd0", 64'(rd_en[0]), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("trap drain_rd", 64'(rd_en[0]), 64'd0);
        end
        tick(1);
        chk("trap first_rd_en", 64'(rd_en[0]), 64'd1);
        chk("trap first_rd_addr", 64'(rd_addr[0]), 64'd8192);
        wait_done(0, 200, c);
        chk("trap throughput", 64'(c), 64'd30);
        chk("trap timeout", 64'(timeout[0]), 64'd0);
        chk("trap done_halt", 64'(halt[0]), 64'd1);
        chk("trap done_valid", 64'(dump_valid[0]), 64'd0);
        chk("trap count_final", 64'(cycle_count[0]), 64'd101);
        chk("trap reads", 64'(rd_cnt[0] - s), 64'd10);
        chk("trap queue_empty", 64'(exp_q[0].size()), 64'd0);

        // Backpressure: ready low 5 cycles per word
        reset[0] = 1'b1;
        tick(1);
        reset_check(0);
        reset[0] = 1'b0;
        dump_ready[0] = 1'b0;
        push_words(0, 32'd8192, 10);
        tick(3);
        trap(0);
        for (int k = 0; k < 10; k++) take_word(0, 5);
        wait_done(0, 20, c);
        chk("bp queue_empty", 64'(exp_q[0].size()), 64'd0);

        // Reset while word 3 is stalled in SEND, then a fresh dump
        reset[0] = 1'b1;
        tick(1);
        reset[0] = 1'b0;
        push_words(0, 32'd8192, 3);
        tick(2);
        trap(0);
        for (int k = 0; k < 3; k++) take_word(0, 0);
        c = 0;
        while (!dump_valid[0] && c < 100) begin
            tick(1);
            c++;
        end
        chk("midrst word3_addr", 64'(dump_addr[0]), 64'd8204);
        chk("midrst word3_data", 64'(dump_data[0]), 64'd10);
        tick(2);
        reset[0] = 1'b1;
        tick(1);
        reset_check(0);
        chk("midrst queue_empty", 64'(exp_q[0].size()), 64'd0);
        reset[0] = 1'b0;
        dump_ready[0] = 1'b1;
        push_words(0, 32'd8192, 10);
        tick(2);
        trap(0);
        wait_done(0, 200, c);
        chk("midrst redump_timeout", 64'(timeout[0]), 64'd0);
        chk("midrst redump_queue", 64'(exp_q[0].size()), 64'd0);
        reset[0] = 1'b1;

        // Timeout after 50 RUN cycles
        push_words(1, 32'd8192, 10);
        reset[1] = 1'b0;
        tick(49);
        chk("tmo pre_count", 64'(cycle_count[1]), 64'd49);
        chk("tmo pre_halt", 64'(halt[1]), 64'd0);
        chk("tmo pre_flag", 64'(timeout[1]), 64'd0);
        tick(1);
        chk("tmo halt", 64'(halt[1]), 64'd1);
        chk("tmo flag", 64'(timeout[1]), 64'd1);
        chk("tmo count", 64'(cycle_count[1]), 64'd50);
        wait_done(1, 200, c);
        chk("tmo count_final", 64'(cycle_count[1]), 64'd50);
        chk("tmo flag_sticky", 64'(timeout[1]), 64'd1);
        chk("tmo queue_empty", 64'(exp_q[1].size()), 64'd0);

        // Trap on the same cycle as the timeout
        reset[1] = 1'b1;
        tick(1);
        reset_check(1);
        push_words(1, 32'd8192, 10);
        reset[1] = 1'b0;
        tick(49);
        trap(1);
        chk("both halt", 64'(halt[1]), 64'd1);
        chk("both timeout", 64'(timeout[1]), 64'd0);
        chk("both count", 64'(cycle_count[1]), 64'd50);
        wait_done(1, 200, c);
        chk("both timeout_final", 64'(timeout[1]), 64'd0);
        chk("both queue_empty", 64'(exp_q[1].size()), 64'd0);
        reset[1] = 1'b1;

        // DUMP_WORDS=0: DRAIN straight to DONE
        s = rd_cnt[2];
        reset[2] = 1'b0;
        tick(5);
        trap(2);
        chk("zero halt", 64'(halt[2]), 64'd1);
        tick(3);
        chk("zero not_done", 64'(done[2]), 64'd0);
        tick(1);
        chk("zero done", 64'(done[2]), 64'd1);
        tick(3);
        chk("zero no_reads", 64'(rd_cnt[2] - s), 64'd0);
        chk("zero no_valid", 64'(dump_valid[2]), 64'd0);
        chk("zero halt_held", 64'(halt[2]), 64'd1);

        // Base near the top of the address space wraps to 0
        exp_q[3].push_back({32'hFFFF_FFF8, 32'd1});
        exp_q[3].push_back({32'hFFFF_FFFC, 32'd4});
        exp_q[3].push_back({32'h0000_0000, 32'd7});
        exp_q[3].push_back({32'h0000_0004, 32'd10});
        s = rd_cnt[3];
        reset[3] = 1'b0;
        tick(3);
        trap(3);
        wait_done(3, 100, c);
        chk("wrap reads", 64'(rd_cnt[3] - s), 64'd4);
        chk("wrap queue_empty", 64'(exp_q[3].size()), 64'd0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
